// File: rtl/cam_arbiter_pkg.sv
// Shared CAM types plus the arbiter's op and state encodings.
package cam_types_pkg;
   localparam int NUM_REQ_DFLT = 4;
   localparam int CAM_KEY_W    = 16;
   localparam int CAM_VAL_W    = 16;

   typedef logic [CAM_KEY_W-1:0] key_t;
   typedef logic [CAM_VAL_W-1:0] val_t;

   typedef enum logic {
      CAM_READ  = 1'b0,
      CAM_WRITE = 1'b1
   } cam_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;
endpackage

// File: rtl/cam_arbiter_if.sv
// Requester-side request/response bundle: per-requester valid/ready request, one-hot response pulse.
interface cam_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int KEY_W   = 16,
   parameter int VAL_W   = 16
);
   logic [NUM_REQ-1:0]       req_valid_i;
   logic [NUM_REQ-1:0]       req_ready_o;
   logic [NUM_REQ-1:0]       req_rw_i;
   logic [NUM_REQ*KEY_W-1:0] req_key_i;
   logic [NUM_REQ*VAL_W-1:0] req_val_i;
   logic [NUM_REQ-1:0]       resp_valid_o;
   logic                     resp_hit_o;
   logic [VAL_W-1:0]         resp_val_o;

   modport master (
      output req_valid_i, req_rw_i, req_key_i, req_val_i,
      input  req_ready_o, resp_valid_o, resp_hit_o, resp_val_o
   );

   modport slave (
      input  req_valid_i, req_rw_i, req_key_i, req_val_i,
      output req_ready_o, resp_valid_o, resp_hit_o, resp_val_o
   );
endinterface

// File: rtl/cam_arbiter_rr_arbiter.sv
// Round-robin select: grants the first requester at or after the pointer, combinationally.
// Pointer moves to one past the winner only when a grant is taken (i_en with a valid request).
module rr_arbiter
   import cam_types_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DFLT,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   w_c;
   logic             w_found;
   logic [IDX_W-1:0] w_idx;

   // Scan from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_c     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_c = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_c >= (IDX_W+1)'(NUM_REQ))
            w_c = w_c - (IDX_W+1)'(NUM_REQ);
         if (i_req[w_c[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_c[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      o_gnt = '0;
      if (i_en && w_found)
         o_gnt[w_idx] = 1'b1;
   end

   assign o_idx = w_idx;
   assign o_any = i_en && w_found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if (o_any)
         r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
   end
endmodule

// File: rtl/cam_arbiter.sv
// Round-robin sharing of a single-ported CAM; one op in flight, one-cycle one-hot response pulse.
// Read latency 3+CAM_LAT-1 cycles grant-to-response, write 2; ready only in IDLE, responses unthrottled.
module cam_arbiter
   import cam_types_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DFLT,
   parameter int KEY_W   = CAM_KEY_W,
   parameter int VAL_W   = CAM_VAL_W,
   parameter int CAM_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   cam_arbiter_if.slave     req_if,
   output logic             cam_valid_o,
   output logic             cam_rw_o,
   output logic [KEY_W-1:0] cam_key_o,
   output logic [VAL_W-1:0] cam_val_o,
   input  logic [VAL_W-1:0] cam_rdata_i,
   input  logic             cam_hit_i,
   output logic             busy_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(CAM_LAT) + 1;

   arb_state_e       r_state;
   logic [IDX_W-1:0] r_owner;
   cam_op_e          r_op;
   logic [KEY_W-1:0] r_key;
   logic [VAL_W-1:0] r_val;
   logic [CNT_W-1:0] r_cnt;
   logic             r_hit;
   logic [VAL_W-1:0] r_rdata;

   logic               w_en;
   logic               w_any;
   logic               w_issue;
   logic [NUM_REQ-1:0] w_gnt;
   logic [IDX_W-1:0]   w_idx;
   logic               w_rw;
   logic [KEY_W-1:0]   w_key;
   logic [VAL_W-1:0]   w_val;

   assign w_en = (r_state == IDLE) && !rst;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .i_req (req_if.req_valid_i),
      .i_en  (w_en),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign req_if.req_ready_o = w_gnt;

   always_comb begin
      w_rw  = 1'b0;
      w_key = '0;
      w_val = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_rw  = req_if.req_rw_i[i];
            w_key = req_if.req_key_i[i*KEY_W +: KEY_W];
            w_val = req_if.req_val_i[i*VAL_W +: VAL_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_op    <= CAM_READ;
         r_key   <= '0;
         r_val   <= '0;
         r_cnt   <= '0;
         r_hit   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_idx;
                  r_op    <= cam_op_e'(w_rw);
                  r_key   <= w_key;
                  r_val   <= w_val;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               // Writes answer with hit=0/data=0, so clear the capture regs up front.
               r_hit   <= 1'b0;
               r_rdata <= '0;
               r_cnt   <= CNT_W'(CAM_LAT - 1);
               r_state <= (r_op == CAM_WRITE) ? RESP : WAIT;
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_hit   <= cam_hit_i;
                  r_rdata <= cam_hit_i ? cam_rdata_i : '0;
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_issue     = (r_state == ISSUE);
   assign cam_valid_o = w_issue;
   assign cam_rw_o    = w_issue && (r_op == CAM_WRITE);
   assign cam_key_o   = w_issue ? r_key : '0;
   assign cam_val_o   = w_issue ? r_val : '0;
   assign busy_o      = (r_state != IDLE);

   always_comb begin
      req_if.resp_valid_o = '0;
      if (r_state == RESP)
         req_if.resp_valid_o[r_owner] = 1'b1;
   end

   assign req_if.resp_hit_o = (r_state == RESP) && r_hit;
   assign req_if.resp_val_o = (r_state == RESP) ? r_rdata : '0;
endmodule

// File: tb/tb_cam_arbiter.sv
// Randomized requesters against a round-robin/latency reference model with a response scoreboard.
`timescale 1ns/1ps
module tb_cam_arbiter;
   import cam_types_pkg::*;

   localparam int N    = 4;
   localparam int KW   = 16;
   localparam int VW   = 16;
   localparam int LAT  = 1;
   localparam int LAT4 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- DUT, CAM_LAT = 1 ----------------
   cam_arbiter_if #(.NUM_REQ(N), .KEY_W(KW), .VAL_W(VW)) rif();
   logic          cam_valid, cam_rw, cam_hit, busy;
   logic [KW-1:0] cam_key;
   logic [VW-1:0] cam_val, cam_rdata;

   cam_arbiter #(.NUM_REQ(N), .KEY_W(KW), .VAL_W(VW), .CAM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_if(rif),
      .cam_valid_o(cam_valid), .cam_rw_o(cam_rw), .cam_key_o(cam_key), .cam_val_o(cam_val),
      .cam_rdata_i(cam_rdata), .cam_hit_i(cam_hit), .busy_o(busy)
   );

   // ---------------- DUT, CAM_LAT = 4 ----------------
   cam_arbiter_if #(.NUM_REQ(N), .KEY_W(KW), .VAL_W(VW)) rif4();
   logic          cam_valid4, cam_rw4, cam_hit4, busy4;
   logic [KW-1:0] cam_key4;
   logic [VW-1:0] cam_val4, cam_rdata4;

   cam_arbiter #(.NUM_REQ(N), .KEY_W(KW), .VAL_W(VW), .CAM_LAT(LAT4)) dut4 (
      .clk(clk), .rst(rst), .req_if(rif4),
      .cam_valid_o(cam_valid4), .cam_rw_o(cam_rw4), .cam_key_o(cam_key4), .cam_val_o(cam_val4),
      .cam_rdata_i(cam_rdata4), .cam_hit_i(cam_hit4), .busy_o(busy4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (bound expired)", name);
   endtask

   // ---------------- CAM behavioural models ----------------
   logic [VW-1:0] cmem [logic [KW-1:0]];
   bit            c_pend;
   int            c_d;
   logic          c_hit;
   logic [VW-1:0] c_val;

   initial begin
      cam_hit   = 1'b0;
      cam_rdata = '0;
      c_pend    = 0;
      forever begin
         @(negedge clk);
         if (!rst && cam_valid) begin
            if (cam_rw) cmem[cam_key] = cam_val;
            else begin
               c_pend = 1;
               c_d    = LAT;
               c_hit  = cmem.exists(cam_key);
               c_val  = c_hit ? cmem[cam_key] : (VW'($urandom) | 16'h0001);
            end
         end
         @(posedge clk);
         #1;
         if (c_pend) c_d--;
         if (c_pend && c_d == 0) begin
            cam_hit   = c_hit;
            cam_rdata = c_val;
            c_pend    = 0;
         end else begin
            cam_hit   = 1'($urandom % 2);
            cam_rdata = VW'($urandom);
         end
      end
   end

   bit            c4_pend;
   int            c4_d;
   logic [KW-1:0] c4_key;

   // Odd keys hit with data key^A5A5; outside the due cycle the bus carries a spurious hit.
   initial begin
      cam_hit4   = 1'b0;
      cam_rdata4 = '0;
      c4_pend    = 0;
      forever begin
         @(negedge clk);
         if (!rst && cam_valid4 && !cam_rw4) begin
            c4_pend = 1;
            c4_d    = LAT4;
            c4_key  = cam_key4;
         end
         @(posedge clk);
         #1;
         if (c4_pend) c4_d--;
         if (c4_pend && c4_d == 0) begin
            cam_hit4   = c4_key[0];
            cam_rdata4 = c4_key[0] ? (c4_key ^ 16'hA5A5) : 16'hFFFF;
            c4_pend    = 0;
         end else begin
            cam_hit4   = 1'b1;
            cam_rdata4 = VW'($urandom);
         end
      end
   end

   // ---------------- reference model ----------------
   typedef struct { int owner; logic hit; logic [VW-1:0] val; } resp_t;
   typedef struct { logic rw; logic [KW-1:0] key; logic [VW-1:0] val; } camop_t;
   resp_t  sbq [$];
   camop_t camq[$];
   logic [VW-1:0] shadow [logic [KW-1:0]];

   int            mp = 0, ph = 0, last = 0, g;
   bit            active = 0;
   logic [N-1:0]  exp_rdy;
   logic          m_rw;
   logic [KW-1:0] m_key;
   logic [VW-1:0] m_val;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("rst_ready", rif.req_ready_o, 0);
         chk("rst_resp_valid", rif.resp_valid_o, 0);
         chk("rst_resp_data", {rif.resp_hit_o, rif.resp_val_o}, 0);
         chk("rst_cam", {cam_valid, cam_rw, cam_key, cam_val}, 0);
         chk("rst_busy", busy, 0);
         mp     = 0;
         active = 0;
         sbq.delete();
         camq.delete();
      end else begin
         g       = -1;
         exp_rdy = '0;
         if (!active)
            for (int k = 0; k < N; k++)
               if (g < 0 && rif.req_valid_i[(mp + k) % N]) g = (mp + k) % N;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("ready", rif.req_ready_o, exp_rdy);
         chk("busy", busy, active);
         chk("cam_valid_timing", cam_valid, active && ph == 1);
         chk("resp_timing", rif.resp_valid_o != 0, active && ph == last);
         if (active) begin
            if (ph == last) active = 0;
            else ph++;
         end else if (g >= 0) begin
            m_rw  = rif.req_rw_i[g];
            m_key = rif.req_key_i[g*KW +: KW];
            m_val = rif.req_val_i[g*VW +: VW];
            camq.push_back('{m_rw, m_key, m_rw ? m_val : '0});
            if (m_rw) begin
               shadow[m_key] = m_val;
               sbq.push_back('{g, 1'b0, '0});
            end else if (shadow.exists(m_key)) begin
               sbq.push_back('{g, 1'b1, shadow[m_key]});
            end else begin
               sbq.push_back('{g, 1'b0, '0});
            end
            active = 1;
            ph     = 1;
            last   = m_rw ? 2 : 2 + LAT;
            mp     = (g + 1) % N;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   resp_t  me;
   camop_t mc;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (rif.resp_valid_o != 0) begin
            if (sbq.size() == 0) fail("resp_unexpected");
            else begin
               me = sbq.pop_front();
               chk("resp_owner", rif.resp_valid_o, 64'(1) << me.owner);
               chk("resp_hit", rif.resp_hit_o, me.hit);
               chk("resp_val", rif.resp_val_o, me.val);
            end
         end
         if (cam_valid) begin
            if (camq.size() == 0) fail("cam_unexpected");
            else begin
               mc = camq.pop_front();
               chk("cam_rw", cam_rw, mc.rw);
               chk("cam_key", cam_key, mc.key);
               if (mc.rw) chk("cam_val", cam_val, mc.val);
            end
         end else begin
            chk("cam_idle_zero", {cam_rw, cam_key, cam_val}, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   int st [N];
   int tmo[N];

   task automatic run_cycles(input int n, input logic [N-1:0] en, input int prob, input int abandon);
      logic [N-1:0] rdy, rsp;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         rdy = rif.req_ready_o;
         rsp = rif.resp_valid_o;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            case (st[i])
               0: if (en[i] && $urandom_range(0, 99) < prob) begin
                     rif.req_valid_i[i]        = 1'b1;
                     rif.req_rw_i[i]           = 1'($urandom % 2);
                     rif.req_key_i[i*KW +: KW] = KW'($urandom_range(0, 7));
                     rif.req_val_i[i*VW +: VW] = VW'($urandom);
                     st[i]  = 1;
                     tmo[i] = 0;
                  end
               1: if (rdy[i]) begin
                     rif.req_valid_i[i] = 1'b0;
                     st[i]  = 2;
                     tmo[i] = 0;
                  end else if ($urandom_range(0, 99) < abandon) begin
                     rif.req_valid_i[i] = 1'b0;
                     st[i] = 0;
                  end else if (++tmo[i] > 200) begin
                     fail("grant_timeout");
                     rif.req_valid_i[i] = 1'b0;
                     st[i] = 0;
                  end
               default: if (rsp[i]) st[i] = 0;
                  else if (++tmo[i] > 200) begin
                     fail("resp_timeout");
                     st[i] = 0;
                  end
            endcase
         end
      end
   endtask

   task automatic one_op(input int i, input logic rw, input logic [KW-1:0] key, input logic [VW-1:0] val);
      bit got;
      @(posedge clk);
      #1;
      rif.req_valid_i[i]        = 1'b1;
      rif.req_rw_i[i]           = rw;
      rif.req_key_i[i*KW +: KW] = key;
      rif.req_val_i[i*VW +: VW] = val;
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = rif.req_ready_o[i];
      end
      if (!got) fail("one_op_grant");
      @(posedge clk);
      #1;
      rif.req_valid_i[i] = 1'b0;
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         got = rif.resp_valid_o[i];
      end
      if (!got) fail("one_op_resp");
   endtask

   task automatic lat4_read(input logic [KW-1:0] key);
      int cv_t, cv_n, rv_t, rv_n;
      cv_t = -1; cv_n = 0; rv_t = -1; rv_n = 0;
      @(posedge clk);
      #1;
      rif4.req_valid_i[1]        = 1'b1;
      rif4.req_rw_i[1]           = 1'b0;
      rif4.req_key_i[1*KW +: KW] = key;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (t == 0) chk("lat4_ready", rif4.req_ready_o, 4'b0010);
         if (t == 3) chk("lat4_busy_wait", busy4, 1);
         if (t == 7) chk("lat4_busy_idle", busy4, 0);
         if (cam_valid4) begin
            cv_n++;
            cv_t = t;
            chk("lat4_cam_key", cam_key4, key);
         end
         if (rif4.resp_valid_o != 0) begin
            rv_n++;
            rv_t = t;
            chk("lat4_resp_owner", rif4.resp_valid_o, 4'b0010);
            chk("lat4_resp_hit", rif4.resp_hit_o, key[0]);
            chk("lat4_resp_val", rif4.resp_val_o, key[0] ? (key ^ 16'hA5A5) : 16'h0000);
         end
         @(posedge clk);
         #1;
         if (t == 0) rif4.req_valid_i[1] = 1'b0;
      end
      chk("lat4_cam_valid_cycle", cv_t, 1);
      chk("lat4_cam_valid_count", cv_n, 1);
      chk("lat4_resp_cycle", rv_t, 6);
      chk("lat4_resp_count", rv_n, 1);
   endtask

   initial begin
      rif.req_valid_i  = '0; rif.req_rw_i  = '0; rif.req_key_i  = '0; rif.req_val_i  = '0;
      rif4.req_valid_i = '0; rif4.req_rw_i = '0; rif4.req_key_i = '0; rif4.req_val_i = '0;
      for (int i = 0; i < N; i++) begin
         st[i]  = 0;
         tmo[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      one_op(0, 1'b1, 16'h0001, 16'h00AA);
      one_op(0, 1'b0, 16'h0002, 16'h0000);
      one_op(2, 1'b1, 16'h1234, 16'hBEEF);
      one_op(2, 1'b0, 16'h1234, 16'h0000);

      run_cycles(200, 4'b1111, 100, 0);
      run_cycles(150, 4'b1010, 100, 0);
      run_cycles(1500, 4'b1111, 30, 3);
      run_cycles(40, 4'b0000, 0, 0);

      // Reset while a read from requester 1 sits in WAIT; the pointer must restart at 0.
      @(posedge clk);
      #1;
      rif.req_valid_i[1]        = 1'b1;
      rif.req_rw_i[1]           = 1'b0;
      rif.req_key_i[1*KW +: KW] = 16'h0003;
      begin
         bit got;
         got = 0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = rif.req_ready_o[1];
         end
         if (!got) fail("rst_test_grant");
      end
      @(posedge clk);
      #1;
      rif.req_valid_i[1] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rif.req_valid_i[0] = 1'b1;
      rif.req_rw_i[0]    = 1'b0;
      rif.req_valid_i[2] = 1'b1;
      rif.req_rw_i[2]    = 1'b0;
      for (int i = 0; i < N; i++) begin
         st[i]  = 0;
         tmo[i] = 0;
      end
      st[0] = 1;
      st[2] = 1;
      @(negedge clk);
      chk("post_rst_grant", rif.req_ready_o, 4'b0001);
      run_cycles(200, 4'b1111, 40, 0);
      run_cycles(40, 4'b0000, 0, 0);

      lat4_read(16'h0005);
      lat4_read(16'h0006);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("lat4_spurious_idle", rif4.resp_valid_o, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule

// File: doc/cam_arbiter.md
Name: cam_arbiter

Overview:
Shares the single-ported CAM among NUM_REQ requesters using round-robin arbitration.
- Each requester issues a read (lookup by key) or write (key, value) with a valid/ready handshake.
- The block sequences exactly one CAM operation at a time and returns a one-cycle response pulse to the owning requester.
- It sits between the requester agents and the CAM, alongside the existing cam_if bench.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_W, 16, key width; must equal the width of key_t in cam_types_pkg
VAL_W, 16, value width; must equal the width of val_t in cam_types_pkg
CAM_LAT, 1, cycles from cam_valid_o high to cam_rdata_i/cam_hit_i valid (1..4)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_rw_i  in  NUM_REQ  per-requester op: 0 = read, 1 = write
req_key_i  in  NUM_REQ*KEY_W  packed keys; requester i occupies [i*KEY_W +: KEY_W]
req_val_i  in  NUM_REQ*VAL_W  packed write values
resp_valid_o  out  NUM_REQ  one-hot response pulse to the owner
resp_hit_o  out  1  read hit; 0 for writes
resp_val_o  out  VAL_W  read data; 0 on a miss or a write
cam_valid_o  out  1  CAM operation strobe
cam_rw_o  out  1  0 = read, 1 = write
cam_key_o  out  KEY_W  key to CAM
cam_val_o  out  VAL_W  write value to CAM
cam_rdata_i  in  VAL_W  CAM read data
cam_hit_i  in  1  CAM hit flag
busy_o  out  1  high in any state except IDLE

Behaviour:
Reset values:
- State = IDLE; rr pointer = 0.
- All outputs 0; latched request fields = 0.

States:
- IDLE: if any req_valid_i is set, grant the first requester at or after the pointer (wrapping modulo NUM_REQ).
  - req_ready_o[g] = 1 combinationally in that cycle.
  - Latch op, key, value and owner g; pointer <= (g+1) mod NUM_REQ.
  - Go to ISSUE. With no valid requests, stay in IDLE and hold the pointer.
- ISSUE: cam_valid_o = 1 for exactly one cycle with the latched fields.
  - Write → RESP.
  - Read → WAIT, with the wait counter set to CAM_LAT-1.
- WAIT: decrement the counter each cycle.
  - When the counter is 0, capture cam_rdata_i and cam_hit_i into registers and go to RESP.
  - The counter width is clog2(CAM_LAT)+1.
- RESP: resp_valid_o[owner] = 1 for one cycle.
  - Read: resp_hit_o = captured hit; resp_val_o = captured data if hit, else 0.
  - Write: resp_hit_o = 0, resp_val_o = 0.
  - Go to IDLE.

Handshake rules:
- A requester holds valid and its fields stable until it sees ready.
- Ready is never asserted outside IDLE.
- Responses have no backpressure.
- A requester must not reissue until it sees its response.

Latency (CAM_LAT=1):
- Read: ready@0, cam_valid@1, CAM data@2, resp@3, next grant earliest @4.
- Write: ready@0, cam_valid@1, resp@2, next grant @3.

Boundary conditions:
- cam_* outputs are 0 whenever cam_valid_o = 0.
- All requests valid at once: grants rotate strictly. After g, the next grant is g+1 even if lower indices are valid.
- Pointer at NUM_REQ-1 wraps to 0.
- A request deasserted before grant is simply not granted (this violates the protocol but must not lock up the arbiter).
- rst mid-operation immediately returns to IDLE. The in-flight op produces no response, and the pointer returns to 0.
- A CAM response arriving outside WAIT is ignored.

Decomposition:
- cam_types_pkg gains:
  - key_t and val_t, if not already present;
  - cam_op_e (CAM_READ=0, CAM_WRITE=1);
  - arb_state_e (IDLE, ISSUE, WAIT, RESP);
  - the NUM_REQ default constant.
- One sub-module, rr_arbiter: combinational rotate-priority-select over NUM_REQ plus the registered pointer update, enabled by grant. The FSM and latches stay in cam_arbiter.

Test Plan:
- Single read, CAM_LAT=1: requester 2 reads key 0x1234, CAM returns hit=1, data 0xBEEF → ready[2]@0, cam_valid@1 with key 0x1234, resp_valid=4'b0100@3, hit=1, val 0xBEEF.
- Write then read-miss: requester 0 writes (0x0001, 0x00AA) → resp@2 with hit=0, val=0. It then reads key 0x0002, CAM hit=0 with rdata=0x5555 → resp_hit=0, resp_val=0.
- Fairness: all 4 requesters hold valid for 16 operations → grant order 0,1,2,3,0,1,… with no requester granted twice before all others are served.
- Wrap and sparse requests: pointer at 3, only requesters 1 and 3 valid → grant 3, then 1, then 3.
- CAM_LAT=4: read → cam_valid@1, data sampled when valid @5, resp@6. A spurious cam_hit_i pulse while in IDLE produces no resp_valid.
- Reset mid-read: assert rst in WAIT → all outputs 0 the same cycle, no response pulse, and the next grant after reset starts from requester 0.
